pc_fetch_unit: RTL and testbench

Holds the program counter and runs the instruction-fetch handshake with instruction memory, directly downstream of the branch next-PC select. It publishes `pc` and `npc = pc + 4` (the fall-through input of the next-PC select), accepts the selected `next_pc` back, and delivers one instruction per fetch to decode. A stall input freezes the PC and the delivered instruction until decode consumes it.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_fetch_unit_pc_reg.sv | 26 ++
 rtl/pc_fetch_unit.sv | 111 +++++++++++
 tb/tb_pc_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the MIPS-style front end.
// Used by pc_fetch_unit, whose optional check is enabled by PC_ALIGN_CHECK_EN.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DELIVER = 2'd2,
    ST_ERR     = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // A fetch address is word aligned when its two byte-offset bits are clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register: synchronous active-low reset to RESET_PC, load enable.
// Part of pc_fetch_unit (optional PC_ALIGN_CHECK_EN does not affect this block).
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // PC holds its value unless the fetch FSM retires the delivered instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction-fetch handshake feeding decode.
// Define PC_ALIGN_CHECK_EN to trap misaligned PCs in a terminal error state.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_err
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         pc_load;
  logic         misaligned;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (pc_load),
    .d    (next_pc),
    .q    (pc)
  );

  assign npc = pc + INSTR_BYTES;

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned   = is_misaligned(pc);
  assign imem_addr    = pc;
  assign misalign_err = (state == ST_ERR);
`else
  // Without the check the low PC bits are simply dropped on the bus.
  assign misaligned   = 1'b0;
  assign imem_addr    = {pc[31:2], 2'b00};
  assign misalign_err = 1'b0;
`endif

  // Handshake outputs come from the state register only, never from inputs.
  assign imem_req    = (state == ST_REQ) && !misaligned;
  assign instr_valid = (state == ST_DELIVER);

  // Next-state and PC-load decode.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    case (state)
      ST_BOOT: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        if (misaligned) begin
          state_next = ST_ERR;
        end else if (imem_ready) begin
          state_next = ST_DELIVER;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_DELIVER: begin
        if (!stall) begin
          state_next = ST_REQ;
          pc_load    = 1'b1;
        end else begin
          state_next = ST_DELIVER;
        end
      end
      ST_ERR: begin
`ifdef PC_ALIGN_CHECK_EN
        state_next = ST_ERR;
`else
        state_next = ST_BOOT;
`endif
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // State register; reset aborts any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Instruction register captures the returned word only while requesting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr <= 32'h0000_0000;
    end else if ((state == ST_REQ) && !misaligned && imem_ready) begin
      instr <= imem_rdata;
    end else begin
      instr <= instr;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: transaction-level model plus directed literal checks.
// Expectations follow PC_ALIGN_CHECK_EN when the bench is built with that macro.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall, imem_ready;
  logic        imem_req, instr_valid, misalign_err;
  logic [31:0] next_pc, pc, npc, imem_addr, imem_rdata, instr;

  logic        use_seq;
  logic [31:0] fixed_pc;
  int          n_checks = 0;
  int          n_err = 0;
  bit          started = 1'b0;

  // Model: where the fetch stands in terms of "waiting to start / fetching / holding a word".
  logic [31:0] m_pc, m_instr;
  bit          m_boot, m_fetch, m_have, m_err;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_pc     (next_pc),
    .stall       (stall),
    .pc          (pc),
    .npc         (npc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .misalign_err(misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] p);
`ifdef PC_ALIGN_CHECK_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  function automatic bit bad_align(input logic [31:0] p);
`ifdef PC_ALIGN_CHECK_EN
    return (p[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign next_pc    = use_seq ? (m_pc + 32'd4) : fixed_pc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_instr <= 32'd0;
      m_boot <= 1'b1; m_fetch <= 1'b0; m_have <= 1'b0; m_err <= 1'b0;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_fetch <= 1'b1;
    end else if (m_fetch) begin
      if (bad_align(m_pc)) begin
        m_fetch <= 1'b0; m_err <= 1'b1;
      end else if (imem_ready) begin
        m_instr <= mem_word(exp_addr(m_pc));
        m_fetch <= 1'b0; m_have <= 1'b1;
      end
    end else if (m_have && !stall) begin
      m_pc <= next_pc; m_have <= 1'b0; m_fetch <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (started) begin
        chk("pc", pc, m_pc);
        chk("npc", npc, m_pc + 32'd4);
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetch && !bad_align(m_pc)});
        chk("imem_addr", imem_addr, exp_addr(m_pc));
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_err});
        if (m_have) chk("instr", instr, m_instr);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [31:0] addr_q[$];
  int          cyc_q[$];
  int          cnt;

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    use_seq = 1'b1; fixed_pc = 32'd0;
    fork
      compare_loop();
    join_none

    // Reset held for 3 edges
    step(1);
    started = 1'b1;
    step(2);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_npc", npc, 32'h0000_0004);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr", instr, 32'd0);

    // Zero-wait sequential fetch
    rst_n = 1'b1; imem_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (imem_req) begin
        addr_q.push_back(imem_addr);
        cyc_q.push_back(i);
      end
    end
    chk("seq_count", addr_q.size(), 32'd4);
    for (int k = 0; k < 4 && k < addr_q.size(); k++) begin
      chk("seq_addr", addr_q[k], 32'(4 * k));
      chk("seq_cycle", cyc_q[k], 32'(1 + 2 * k));
    end
    chk("seq_last_instr", instr, mem_word(32'd12));

    // Three wait states, then a four-cycle stall
    imem_ready = 1'b0; cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (imem_req) cnt++;
    end
    imem_ready = 1'b1; stall = 1'b1;
    step(1);
    chk("wait_req_cycles", cnt, 32'd4);
    chk("wait_instr", instr, mem_word(32'd16));
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, mem_word(32'd16));
      chk("stall_pc", pc, 32'd16);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end

    // Branch redirect and wrap
    stall = 1'b0; use_seq = 1'b0; fixed_pc = 32'h0000_0040;
    step(1);
    chk("redir_addr", imem_addr, 32'h0000_0040);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    step(1);
    fixed_pc = 32'hFFFF_FFFC;
    step(1);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_npc", npc, 32'h0000_0000);
    step(1);

    // Mid-request reset with a late ready
    fixed_pc = 32'h0000_0100; imem_ready = 1'b0;
    step(2);
    chk("midrst_req_before", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    step(1);
    chk("midrst_pc", pc, 32'h0000_0000);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    step(1);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    imem_ready = 1'b0;
    step(1);
    chk("midrst_instr", instr, 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0000_0000);

    // Misaligned PC
    imem_ready = 1'b1;
    step(1);
    fixed_pc = 32'h0000_0042;
    step(1);
    chk("mis_pc", pc, 32'h0000_0042);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    chk("mis_addr", imem_addr, 32'h0000_0042);
    step(1);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    step(3);
    chk("mis_err_sticky", {31'd0, misalign_err}, 32'd1);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
`else
    chk("mis_req", {31'd0, imem_req}, 32'd1);
    chk("mis_addr", imem_addr, 32'h0000_0040);
    chk("mis_err", {31'd0, misalign_err}, 32'd0);
    step(1);
    chk("mis_instr", instr, mem_word(32'h0000_0040));
`endif
    rst_n = 1'b0;
    step(1);
    chk("final_err_clear", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
